// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI responder.
// Holds the FSM state encoding and the bit-counter width helper.
// No ports; imported by spi_slave_ctrl.
package spi_slave_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } spi_slave_state_t;

   // Width of the per-word bit counter; never narrower than one bit.
   function automatic int unsigned bit_cnt_w(input int unsigned data_w);
      return (data_w < 2) ? 1 : $clog2(data_w);
   endfunction

endpackage

// File: rtl/spi_iface.sv
// SPI pin bundle shared between an SPI master and responder.
// Slave modport: if_ss/if_sclk/if_sdi in, if_sdo out.
// Master modport: the mirror image.
interface SPI_iface;
   logic if_ss;
   logic if_sclk;
   logic if_sdi;
   logic if_sdo;

   modport slave  (input if_ss, input if_sclk, input if_sdi, output if_sdo);
   modport master (output if_ss, output if_sclk, output if_sdi, input if_sdo);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall pulse detection on the synced level.
// Ports: clk/rst_n (sync active-low), d_i async input, q_o synced level,
//        rise_o/fall_o single-cycle pulses; latency STAGES cycles to q_o.
module spi_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~dly_q;
   assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 responder: oversamples SPI pins with clk, deserialises into an RX
// valid/ready buffer and serialises TX words from a one-entry holding register.
// Ports: clk, rst_n (sync active-low), spi (SPI_iface.slave), tx_data/tx_valid/
//        tx_ready, rx_data/rx_valid/rx_ready, rx_overrun, tx_underrun, busy.
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first in both directions.
module spi_slave_ctrl
   import spi_slave_pkg::*;
#(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] TX_IDLE     = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst_n,
   SPI_iface.slave           spi,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   output logic              tx_underrun,
   output logic              busy
);

   localparam int unsigned       CNT_W   = bit_cnt_w(DATA_W);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W - 1);

   // Pin synchronisation; sdi shares the depth so it lines up with sclk edges.
   logic ss_sync, ss_rise, ss_fall;
   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic [SYNC_STAGES-1:0] sdi_sync_q;
   logic sdi_s;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
      .clk(clk), .rst_n(rst_n), .d_i(spi.if_ss),
      .q_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .d_i(spi.if_sclk),
      .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

   spi_slave_state_t  state_q, state_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              tx_ready_q, tx_ready_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_overrun_q, rx_overrun_d;
   logic              tx_underrun_q, tx_underrun_d;
   logic              sdo_q, sdo_d;

   logic              load_evt, word_done, ss_abort, accept, tx_bit;
   logic [DATA_W-1:0] rx_shift, tx_shift;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign rx_shift = {sdi_s, rx_sr_q[DATA_W-1:1]};
   assign tx_shift = {1'b0, tx_sr_q[DATA_W-1:1]};
   assign tx_bit   = tx_sr_q[0];
`else
   assign rx_shift = {rx_sr_q[DATA_W-2:0], sdi_s};
   assign tx_shift = {tx_sr_q[DATA_W-2:0], 1'b0};
   assign tx_bit   = tx_sr_q[DATA_W-1];
`endif

   // ss_rise always implies ss_sync high; both kept for clarity of intent.
   assign ss_abort = ss_rise | ss_sync;
   assign accept   = tx_valid & tx_ready_q;

   always_comb begin
      state_d   = state_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      bit_cnt_d = bit_cnt_q;
      load_evt  = 1'b0;
      word_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall) state_d = LOAD;
         end
         LOAD: begin
            bit_cnt_d = '0;
            if (ss_abort) begin
               state_d = IDLE;
            end else begin
               state_d  = SHIFT;
               load_evt = 1'b1;
               rx_sr_d  = '0;
            end
         end
         SHIFT: begin
            if (ss_abort) begin
               // Partial word and in-flight TX word are dropped; holding reg survives.
               state_d   = IDLE;
               bit_cnt_d = '0;
               rx_sr_d   = '0;
               tx_sr_d   = '0;
            end else begin
               if (sclk_rise) begin
                  rx_sr_d   = rx_shift;
                  word_done = (bit_cnt_q == CNT_MAX);
                  bit_cnt_d = (bit_cnt_q == CNT_MAX) ? '0 : bit_cnt_q + CNT_W'(1);
               end
               // A falling edge after the last bit starts the next word.
               if (sclk_fall) begin
                  if (bit_cnt_q == '0) load_evt = 1'b1;
                  else                 tx_sr_d  = tx_shift;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load_evt) tx_sr_d = hold_full_q ? hold_q : TX_IDLE;
   end

   // TX holding register: a same-cycle accept wins over the load that empties it.
   always_comb begin
      hold_full_d   = accept | (hold_full_q & ~load_evt);
      hold_d        = accept ? tx_data : hold_q;
      tx_ready_d    = ~hold_full_d;
      tx_underrun_d = load_evt & ~hold_full_q;
      sdo_d         = (state_q != IDLE) ? tx_bit : 1'b0;
   end

   // Single-entry RX buffer; a concurrent consume frees the slot for the new word.
   always_comb begin
      rx_valid_d   = rx_valid_q;
      rx_data_d    = rx_data_q;
      rx_overrun_d = 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (word_done) begin
         if (rx_valid_q && !rx_ready) begin
            rx_overrun_d = 1'b1;
         end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sdi_sync_q    <= '0;
         state_q       <= IDLE;
         tx_sr_q       <= '0;
         rx_sr_q       <= '0;
         bit_cnt_q     <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         tx_ready_q    <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_overrun_q  <= 1'b0;
         tx_underrun_q <= 1'b0;
         sdo_q         <= 1'b0;
      end else begin
         sdi_sync_q    <= {sdi_sync_q[SYNC_STAGES-2:0], spi.if_sdi};
         state_q       <= state_d;
         tx_sr_q       <= tx_sr_d;
         rx_sr_q       <= rx_sr_d;
         bit_cnt_q     <= bit_cnt_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         tx_ready_q    <= tx_ready_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         rx_overrun_q  <= rx_overrun_d;
         tx_underrun_q <= tx_underrun_d;
         sdo_q         <= sdo_d;
      end
   end

   assign spi.if_sdo  = sdo_q;
   assign tx_ready    = tx_ready_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_overrun  = rx_overrun_q;
   assign tx_underrun = tx_underrun_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl acting as an SPI mode-0 master.
// Inputs change 2 time units after posedge; outputs checked away from edges.
// Pulses and RX handshakes are recorded on the falling clock edge.
module tb_spi_slave_ctrl;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_overrun;
   logic       tx_underrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int n_ovr    = 0;
   int n_udr    = 0;
   logic [7:0] rxq[$];
   logic [7:0] miso, miso2;
   logic       b;

   always #5 clk = ~clk;

   SPI_iface spi_if ();

   spi_slave_ctrl #(.DATA_W(8), .SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .spi(spi_if),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
   );

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (rx_valid && rx_ready) rxq.push_back(rx_data);
         if (rx_overrun)  n_ovr++;
         if (tx_underrun) n_udr++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One SPI bit: drop sclk if high, present sdi, raise sclk and sample sdo.
   task automatic spi_bit(input logic mo, output logic mi);
      if (spi_if.if_sclk) begin
         tick(HALF);
         spi_if.if_sclk = 1'b0;
      end
      spi_if.if_sdi = mo;
      tick(HALF);
      spi_if.if_sclk = 1'b1;
      mi = spi_if.if_sdo;
   endtask

   task automatic spi_word(input logic [7:0] mo, output logic [7:0] mi);
      logic bit_in;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(mo[i], bit_in);
         mi[i] = bit_in;
      end
   endtask

   task automatic frame_begin();
      spi_if.if_ss = 1'b0;
      tick(10);
   endtask

   task automatic frame_end();
      tick(HALF);
      spi_if.if_sclk = 1'b0;
      tick(HALF);
      spi_if.if_ss = 1'b1;
      tick(10);
   endtask

   task automatic push_tx(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      spi_if.if_ss   = 1'b1;
      spi_if.if_sclk = 1'b0;
      spi_if.if_sdi  = 1'b0;
      tx_data        = 8'h00;
      tx_valid       = 1'b0;
      rx_ready       = 1'b1;
      tick(4);

      // Reset state
      check("rst_sdo", spi_if.if_sdo, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_overrun", rx_overrun, 0);
      check("rst_tx_underrun", tx_underrun, 0);
      check("rst_busy", busy, 0);
      check("rst_tx_ready", tx_ready, 0);
      rst_n = 1'b1;
      tick(1);
      check("post_rst_tx_ready", tx_ready, 1);
      tick(5);

      // Single frame: master sends A5, slave returns preloaded 3C
      push_tx(8'h3C);
      check("t1_tx_ready_full", tx_ready, 0);
      rxq.delete(); n_udr = 0;
      frame_begin();
      check("t1_busy", busy, 1);
      spi_word(8'hA5, miso);
      check("t1_underrun", n_udr, 0);
      frame_end();
      check("t1_miso", miso, 8'h3C);
      check("t1_rx_count", rxq.size(), 1);
      if (rxq.size() > 0) check("t1_rx_word", rxq[0], 8'hA5);
      check("t1_sdo_idle", spi_if.if_sdo, 0);
      check("t1_busy_idle", busy, 0);

      // Back-to-back words within one frame
      push_tx(8'h81);
      rxq.delete(); n_udr = 0;
      frame_begin();
      check("t2_tx_ready_after_load", tx_ready, 1);
      push_tx(8'h7E);
      spi_word(8'h12, miso);
      spi_word(8'h34, miso2);
      check("t2_underrun", n_udr, 0);
      frame_end();
      check("t2_miso0", miso, 8'h81);
      check("t2_miso1", miso2, 8'h7E);
      check("t2_rx_count", rxq.size(), 2);
      if (rxq.size() > 1) begin
         check("t2_rx0", rxq[0], 8'h12);
         check("t2_rx1", rxq[1], 8'h34);
      end

      // No TX word pending at LOAD
      rxq.delete(); n_udr = 0;
      frame_begin();
      spi_word(8'h99, miso);
      check("t3_underrun", n_udr, 1);
      frame_end();
      check("t3_miso", miso, 8'hFF);
      check("t3_rx_count", rxq.size(), 1);

      // Overrun: consumer stalled across two words
      rxq.delete(); n_ovr = 0; rx_ready = 1'b0;
      frame_begin();
      spi_word(8'h55, miso);
      spi_word(8'hAA, miso);
      tick(4);
      check("t4_rx_valid", rx_valid, 1);
      check("t4_rx_data_kept", rx_data, 8'h55);
      check("t4_overrun", n_ovr, 1);
      frame_end();
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check("t4_drain_count", rxq.size(), 1);
      if (rxq.size() > 0) check("t4_drain_word", rxq[0], 8'h55);
      check("t4_rx_valid_clear", rx_valid, 0);

      // Consumer ready exactly on the completion cycle of the second word
      rxq.delete(); n_ovr = 0;
      frame_begin();
      spi_word(8'h55, miso);
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] w;
         w = 8'hAA;
         spi_bit(w[i], b);
      end
      tick(2);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(2);
      check("t4b_rx_valid", rx_valid, 1);
      check("t4b_rx_data", rx_data, 8'hAA);
      check("t4b_overrun", n_ovr, 0);
      check("t4b_consumed", rxq.size(), 1);
      if (rxq.size() > 0) check("t4b_consumed_word", rxq[0], 8'h55);
      frame_end();
      rx_ready = 1'b1;
      tick(2);

      // ss deasserted after 5 bits, then a clean frame
      rxq.delete(); n_ovr = 0;
      frame_begin();
      for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
      frame_end();
      check("t5_no_rx", rxq.size(), 0);
      check("t5_busy", busy, 0);
      check("t5_overrun", n_ovr, 0);
      frame_begin();
      spi_word(8'hC3, miso);
      frame_end();
      check("t5_rx_count", rxq.size(), 1);
      if (rxq.size() > 0) check("t5_rx_word", rxq[0], 8'hC3);

      // Reset pulse mid-frame
      rxq.delete();
      frame_begin();
      for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
      rst_n = 1'b0;
      tick(1);
      check("t6_busy", busy, 0);
      check("t6_sdo", spi_if.if_sdo, 0);
      check("t6_rx_valid", rx_valid, 0);
      check("t6_rx_data", rx_data, 0);
      check("t6_tx_ready", tx_ready, 0);
      check("t6_overrun", rx_overrun, 0);
      check("t6_underrun", tx_underrun, 0);
      rst_n = 1'b1;
      frame_end();
      check("t6_tx_ready_after", tx_ready, 1);
      check("t6_no_rx", rxq.size(), 0);
      frame_begin();
      spi_word(8'h0F, miso);
      frame_end();
      check("t6_rx_count", rxq.size(), 1);
      if (rxq.size() > 0) check("t6_rx_word", rxq[0], 8'h0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
